// File: rtl/dsp_mem_loader.sv
// dsp_mem_loader: write-path loader for one DSP unit.
//
// Takes a 32-bit valid/ready packet stream and turns it into the unit's memory
// write bus. Each packet is one header word followed by len+1 payload words.
// The header gives the region (command or wave memory), the length and the
// start address.
//   cmd  : payload word k goes to bank (k mod MEM_TO_CMD) at buffer address
//          start + k/MEM_TO_CMD.
//   wave : payload word k goes to address start + k.
// Headers with nonzero reserved bits set err and have their payload dropped.
//
// Ports
//   clk            clock
//   reset          asynchronous active-low reset
//   s_data         stream word (header or payload)
//   s_valid        stream word valid
//   s_ready        loader accepts the word this cycle
//   abort          synchronous abort of the current packet
//   mem_write_addr write address, MSB selects cmd (0) or wave (1)
//   mem_write_data write data
//   mem_write_en   write strobe, one cycle after the payload transfer
//   busy           packet in progress (LOAD or DROP)
//   done           one-cycle pulse after the last payload word
//   err            sticky header error, cleared by the next valid header
//   csum           running sum of the payload words (only with DSP_LOADER_CSUM_EN)
//
// Optional feature macro: DSP_LOADER_CSUM_EN adds the csum output.

module dsp_mem_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int CMD_ADDR_WIDTH = 8,
    parameter int MEM_TO_CMD     = 4,
    parameter int LEN_WIDTH      = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      abort,
    output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0]     mem_write_data,
    output logic                      mem_write_en,
    output logic                      busy,
    output logic                      done,
    output logic                      err
`ifdef DSP_LOADER_CSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]     csum
`endif
);

    localparam int SEL_W  = $clog2(MEM_TO_CMD);
    localparam int WAVE_W = MEM_ADDR_WIDTH - 1;
    localparam int PAD_W  = MEM_ADDR_WIDTH - 1 - SEL_W - CMD_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DROP,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    // Low only in the first cycle after reset release, so s_ready stays 0
    // while reset is held and rises on the following cycle.
    logic                      alive;
    logic                      xfer;
    logic                      hdr_rsv;
    logic                      last;
    logic [LEN_WIDTH-1:0]      idx;
    logic [LEN_WIDTH-1:0]      len_q;
    logic                      region_q;
    logic [11:0]               start_q;
    logic [CMD_ADDR_WIDTH-1:0] buf_idx;
    logic [WAVE_W-1:0]         wave_off;
    logic [MEM_ADDR_WIDTH-1:0] addr_calc;

    assign hdr_rsv = |s_data[DATA_WIDTH-2 -: 3];
    assign last    = (idx == len_q);
    assign xfer    = s_valid & s_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            alive <= 1'b0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                s_ready = alive;
                if (s_valid && alive && !abort)
                    state_nxt = hdr_rsv ? ST_DROP : ST_LOAD;
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid && !abort && last)
                    state_nxt = ST_DONE;
            end
            ST_DROP: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid && !abort && last)
                    state_nxt = ST_IDLE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Abort wins over everything and refuses the word presented with it.
        if (abort) begin
            s_ready   = 1'b0;
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        buf_idx  = CMD_ADDR_WIDTH'(start_q[CMD_ADDR_WIDTH-1:0]
                                   + CMD_ADDR_WIDTH'(idx >> SEL_W));
        wave_off = WAVE_W'(start_q) + WAVE_W'(idx);
        if (region_q)
            addr_calc = {1'b1, wave_off};
        else
            addr_calc = {1'b0, {PAD_W{1'b0}}, idx[SEL_W-1:0], buf_idx};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx            <= '0;
            len_q          <= '0;
            region_q       <= 1'b0;
            start_q        <= '0;
            err            <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
        end else begin
            mem_write_en <= 1'b0;
            if (xfer) begin
                case (state)
                    ST_IDLE: begin
                        idx      <= '0;
                        len_q    <= s_data[16 +: LEN_WIDTH];
                        region_q <= s_data[DATA_WIDTH-1];
                        start_q  <= s_data[11:0];
                        err      <= hdr_rsv;
                    end
                    ST_LOAD: begin
                        mem_write_en   <= 1'b1;
                        mem_write_addr <= addr_calc;
                        mem_write_data <= s_data;
                        idx            <= idx + 1'b1;
                    end
                    ST_DROP: idx <= idx + 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef DSP_LOADER_CSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            csum <= '0;
        else if (xfer && state == ST_IDLE)
            csum <= '0;
        else if (xfer && state == ST_LOAD)
            csum <= csum + s_data;
    end
`else
    // No checksum state in this build.
`endif

endmodule

// File: tb/tb_dsp_mem_loader.sv
module tb_dsp_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        abort;
    logic [12:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic        busy;
    logic        done;
    logic        err;
`ifdef DSP_LOADER_CSUM_EN
    logic [31:0] csum;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dsp_mem_loader dut (
        .clk            (clk),
        .reset          (reset),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .abort          (abort),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .busy           (busy),
        .done           (done),
        .err            (err)
`ifdef DSP_LOADER_CSUM_EN
        ,
        .csum           (csum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Address of payload word k, straight from the address mapping rules.
    function automatic logic [31:0] exp_addr(input bit region, input int start, input int k);
        if (!region)
            return 32'(((k % 4) << 8) | ((start + k / 4) % 256));
        else
            return 32'(4096 | ((start + k) % 4096));
    endfunction

    // Drive one cycle's inputs at the falling edge, report whether the word
    // is taken, and return just after the rising edge that acts on it.
    task automatic cycle(input logic v, input logic [31:0] d, input logic ab,
                         output logic rdy, output logic acc);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        abort   = ab;
        #1;
        rdy = s_ready;
        acc = v & s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag);
        logic rdy, acc;
        cycle(1'b0, $urandom, 1'b0, rdy, acc);
        check({tag, "_write"}, mem_write_en, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic send_pkt(input bit region, input bit bad, input int len, input int start,
                            input int gap_pct, input int gap_at, input int abort_at,
                            input logic [31:0] dbase);
        logic        rdy, acc;
        logic [31:0] hdr, w, sum;
        logic [11:0] len12, start12;
        int          tries;
        len12   = len[11:0];
        start12 = start[11:0];
        hdr = {region, (bad ? 3'b001 : 3'b000), len12, 4'h0, start12};
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 8) begin
            cycle(1'b1, hdr, 1'b0, rdy, acc);
            tries++;
        end
        check("hdr_accept", acc, 1);
        if (!acc) return;
        check("hdr_no_write", mem_write_en, 0);
        check("hdr_busy", busy, 1);
        check("hdr_err", err, bad);
        sum = 0;
        for (int k = 0; k <= len; k++) begin
            if (k == abort_at) begin
                cycle(1'b1, $urandom, 1'b1, rdy, acc);
                check("abort_ready", rdy, 0);
                check("abort_write", mem_write_en, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                return;
            end
            if (k == gap_at)
                repeat (3) idle_check("gap");
            while (gap_pct > 0 && $urandom_range(99) < gap_pct)
                idle_check("rgap");
            w = (dbase != 0) ? dbase + 32'(k) : $urandom;
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 8) begin
                cycle(1'b1, w, 1'b0, rdy, acc);
                tries++;
            end
            check("word_accept", acc, 1);
            if (!acc) return;
            if (bad) begin
                check("drop_no_write", mem_write_en, 0);
            end else begin
                check("wr_en", mem_write_en, 1);
                check("wr_addr", 32'(mem_write_addr), exp_addr(region, start, k));
                check("wr_data", mem_write_data, w);
                sum += w;
            end
            if (k < len) check("mid_done", done, 0);
        end
        check("end_busy", busy, 0);
        check("end_done", done, !bad);
        check("end_err", err, bad);
`ifdef DSP_LOADER_CSUM_EN
        if (!bad) check("csum", csum, sum);
`endif
        cycle(1'b0, 32'h0, 1'b0, rdy, acc);
        check("post_ready", rdy, bad);
        check("post_done", done, 0);
        check("post_write", mem_write_en, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic rdy, acc;
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        abort   = 1'b0;
        #12;
        check("rst_ready", s_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wen", mem_write_en, 0);
        check("rst_addr", 32'(mem_write_addr), 0);
        check("rst_data", mem_write_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", s_ready, 1);

        // cmd len=3 start=0x10 with data A0..A3
        send_pkt(1'b0, 1'b0, 3, 'h10, 0, -1, -1, 32'hA0);
        // wave wrapping 4095 -> 0
        send_pkt(1'b1, 1'b0, 4, 'hFFE, 0, -1, -1, 32'h0);
        // cmd buffer wrapping 255 -> 0
        send_pkt(1'b0, 1'b0, 7, 'hFF, 0, -1, -1, 32'h0);
        // reserved bits set, then a valid header clears err
        send_pkt(1'b0, 1'b1, 1, 0, 0, -1, -1, 32'h0);
        send_pkt(1'b0, 1'b0, 2, 'h20, 30, -1, -1, 32'h0);
        // partial trailing command
        send_pkt(1'b0, 1'b0, 5, 'h40, 0, -1, -1, 32'h0);

        // wave len=9: gap of 3 after word 4, abort instead of word 7
        send_pkt(1'b1, 1'b0, 9, 'h7F0, 0, 4, 6, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, rdy, acc);
        check("after_abort_ready", rdy, 1);
        check("after_abort_busy", busy, 0);
        check("after_abort_done", done, 0);
        send_pkt(1'b1, 1'b0, 2, 'h123, 0, -1, -1, 32'h0);

        // reset in the middle of a load
        cycle(1'b1, 32'h800A_0100, 1'b0, rdy, acc);
        check("mid_hdr_accept", acc, 1);
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, rdy, acc);
        check("mid_busy", busy, 1);
        @(negedge clk);
        s_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_ready", s_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_wen", mem_write_en, 0);
        check("arst_addr", 32'(mem_write_addr), 0);
        check("arst_data", mem_write_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("arst_ready_back", s_ready, 1);
        send_pkt(1'b1, 1'b0, 3, 'h555, 0, -1, -1, 32'h0);

        repeat (12)
            send_pkt(1'($urandom_range(1)), ($urandom_range(9) == 0), $urandom_range(20),
                     $urandom_range(4095), 25, -1, -1, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dsp_mem_loader.md
Name: dsp_mem_loader

Overview:
- Upstream write-path stage for one DSP unit.
- Accepts a 32-bit valid/ready packet stream from the host interconnect, decodes packet headers, and generates the unit's memory write bus (mem_write_addr/data/en).
- Command memory: payload words are spread across the MEM_TO_CMD command banks at a shared buffer address.
- Envelope/wave memory: payload words are written at auto-incrementing addresses.

Parameters:
- DATA_WIDTH, 32, stream and memory write data width
- MEM_ADDR_WIDTH, 13, write address width; MSB selects cmd (0) or wave (1)
- CMD_ADDR_WIDTH, 8, command buffer address width
- MEM_TO_CMD, 4, command banks per command word (power of 2)
- LEN_WIDTH, 12, packet length field width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- s_data  input  DATA_WIDTH  stream word (header or payload)
- s_valid  input  1  stream word valid
- s_ready  output  1  loader accepts word
- abort  input  1  synchronous abort of current packet
- mem_write_addr  output  MEM_ADDR_WIDTH  write address to DSP unit
- mem_write_data  output  DATA_WIDTH  write data
- mem_write_en  output  1  write strobe
- busy  output  1  packet in progress
- done  output  1  one-cycle pulse at packet end
- err  output  1  sticky header error; cleared by reset or next valid header

Behaviour:
- Transfer occurs on a rising clk edge with s_valid & s_ready.
- Reset (async, active-low) values: all outputs 0, state IDLE, counters 0.
  - s_ready rises the first cycle after reset deasserts.
- Header word fields:
  - [31] region: 0 = cmd, 1 = wave
  - [30:28] reserved, must be 0
  - [27:16] len = payload words - 1
  - [11:0] start: cmd uses [CMD_ADDR_WIDTH-1:0]; wave uses [11:0]
- States:
  - IDLE: s_ready=1, busy=0. Valid header -> LOAD, err cleared. Reserved bits nonzero -> DROP, err=1.
  - LOAD: s_ready=1, busy=1. Payload index k runs 0..len. Transfer at k==len -> DONE.
  - DROP: s_ready=1, busy=1, no writes. Consumes len+1 words, then -> IDLE; no done pulse.
  - DONE: s_ready=0, busy=0, done=1 for one cycle -> IDLE.
- Address mapping, payload index k:
  - cmd: addr = {1'b0, 2'b00, sel, buf}, where sel = k mod MEM_TO_CMD and buf = (start + k/MEM_TO_CMD) mod 2^CMD_ADDR_WIDTH.
  - wave: addr = {1'b1, (start + k) mod 4096}.
- Latency: every payload transfer produces mem_write_en=1 with the registered addr/data exactly one cycle later.
  - Back-to-back transfers give back-to-back writes.
  - mem_write_en=0 whenever no transfer occurred in the previous cycle.
- s_valid gaps: state and index hold, no writes.
- cmd len+1 not a multiple of MEM_TO_CMD:
  - All words are still written.
  - The trailing partial command is left partial; err is not set.
- Address wrap: cmd buffer wraps 255->0, wave wraps 4095->0, both silently.
- abort:
  - Any state -> IDLE next cycle. A word presented in the same cycle is not accepted (s_ready forced 0 that cycle).
  - No done pulse.
  - A write already registered from the previous cycle still completes.
- Header for the next packet is accepted in IDLE only, so there is one dead cycle (DONE) between packets.

Optional Feature:
- Macro: DSP_LOADER_CSUM_EN.
- When defined:
  - Adds output port csum [DATA_WIDTH-1:0]: a running mod-2^32 sum of all payload words in the current packet.
  - Cleared on header acceptance; valid in the DONE cycle; held until the next header.
  - DROP words are not summed.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then header 0x0003_0010 + payload A0..A3 (cmd, len=3, start=0x10), continuous valid -> writes at addr 0x010/0x110/0x210/0x310 with data A0..A3 on consecutive cycles, each one cycle after its transfer; done pulses once; csum=A0+A1+A2+A3.
- Header 0x8004_0FFE + 5 words (wave, start=0xFFE) -> addrs 0x1FFE, 0x1FFF, 0x1000, 0x1001, 0x1002.
- Cmd header len=7, start=0xFF -> buf 0xFF for k=0..3, then buf 0x00 for k=4..7, with sel cycling 0,1,2,3.
- Header 0x1001_0000 (reserved bit set) + 2 words -> err=1, no mem_write_en, no done. A following valid header clears err and loads normally.
- Wave packet len=9; deassert s_valid for 3 cycles after word 4, then assert abort after word 6 -> exactly 6 writes with addrs contiguous across the gap, no done, s_ready=0 in the abort cycle, IDLE afterwards.
- Assert reset mid-LOAD -> all outputs 0 immediately (async). After release, the next header starts fresh at its own start address.
